ex_div_sequencer: RTL and testbench
===================================

// Module: ex_div_sequencer
// PURPOSE
//   Multi-cycle divide sequencer beside the EX stage: runs MIPS DIV/DIVU as a
//   radix-2 restoring divider and stalls the pipeline while the divide runs.
//   EX raises start with latched operands and holds them while stall_request
//   is high. EX writes the registered {remainder, quotient} result to HI/LO
//   in the result_valid cycle. annul kills an in-flight divide on a flush.
// PARAMETERS
//   WIDTH  32  operand width; result is 2*WIDTH bits; iteration counter is $clog2(WIDTH)+1 bits
// PORTS
//   clock          in   1        rising-edge clock
//   reset          in   1        reset, synchronous, active-high
//   start          in   1        divide request from EX; held high while stall_request=1
//   signed_div     in   1        1=DIV (two's complement), 0=DIVU; sampled with start
//   dividend       in   WIDTH    operand1 (rs); sampled in IDLE on start
//   divisor        in   WIDTH    operand2 (rt); sampled in IDLE on start
//   annul          in   1        flush: abandon current divide, no result
//   stall_request  out  1        to pipeline control: hold IF..EX
//   result_valid   out  1        one-cycle pulse, result is valid
//   result         out  2*WIDTH  {remainder, quotient}
// BEHAVIOUR
//   States: IDLE, ZERO, BUSY, DONE (2-bit encoded register).
//   Reset: state=IDLE, result=0, result_valid=0, counter=0, internal regs=0.
//     Reset has priority over every other input in every state, mid-divide included.
//   IDLE:
//     start=1, annul=0, divisor==0 -> ZERO.
//     start=1, annul=0, divisor!=0 -> BUSY. Latch magnitudes: |x| if signed_div, else raw.
//       Latch q_neg = signed_div & (dividend[MSB]^divisor[MSB]) and r_neg = signed_div & dividend[MSB].
//       Clear the partial remainder and counter.
//     start=1, annul=1 -> stay IDLE.
//   BUSY: one restoring step per cycle.
//     {rem,quo} shifted left by 1; trial = rem - |divisor| (WIDTH+1 bits).
//     Trial non-negative -> rem=trial, quo LSB=1.
//     After WIDTH steps -> DONE.
//   ZERO: one cycle, then DONE with result=0 (MIPS result undefined; fixed to 0 here).
//   DONE: result_valid=1 for exactly this cycle, then -> IDLE.
//     result = {r_neg ? -rem : rem, q_neg ? -quo : quo}.
//     result holds its value until the next DONE.
//   annul=1 in ZERO or BUSY -> IDLE next cycle; no result_valid; result unchanged.
//   annul in DONE is ignored (result already committed).
//   stall_request is combinational: (IDLE & start & ~annul) | ZERO | BUSY. It is 0 in DONE.
//   Latency, start seen in IDLE at cycle T:
//     result_valid at T+WIDTH+1 (T+33 at default WIDTH).
//     Divisor 0 -> result_valid at T+2.
//   Back-to-back: start high in the cycle after DONE (IDLE) begins a new divide.
//     No bubble beyond the DONE->IDLE cycle.
//   Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (wraps, no trap).
//   Quotient truncates toward zero; remainder takes the dividend's sign.
// TESTING
//   DIVU 100/7 at T -> stall high T..T+32, result_valid at T+33, result={32'd2,32'd14}.
//   DIV -7/2 -> result={32'hFFFFFFFF,32'hFFFFFFFD}; DIV 7/-2 -> {32'd1,32'hFFFFFFFD}.
//   DIVU 5/0 at T -> result_valid at T+2, result=64'h0, stall low at T+2.
//   DIV 0x80000000/0xFFFFFFFF -> {32'h0,32'h80000000}.
//     DIVU 0xFFFFFFFF/1 -> {32'h0,32'hFFFFFFFF}.
//   annul at BUSY step 10 -> IDLE and stall low next cycle, no result_valid, result unchanged.
//     A following DIVU 9/3 -> {0,3}.
//   reset held one cycle at BUSY step 20 -> IDLE, result=0, no result_valid.
//     Back-to-back 100/7 then 50/5 -> two pulses 34 cycles apart.

Source files
------------

// File: rtl/ex_div_sequencer.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU beside the EX stage.
// Holds the pipeline through the divide and pulses result_valid with {remainder, quotient}.
module ex_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               annul,
  output logic               stall_request,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ZERO = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH:0]     rem_ext;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;
  logic [WIDTH-1:0]   dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;

    // One restoring step: shift {rem, quo} left and try subtracting the divisor.
    rem_ext = {rem_q, quo_q[WIDTH-1]};
    trial   = rem_ext - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      step_rem = trial[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = rem_ext[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b0};
    end

    dvd_mag = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;

    case (state_q)
      S_IDLE: begin
        if (start && !annul) begin
          if (divisor == '0) begin
            state_d = S_ZERO;
          end else begin
            state_d = S_BUSY;
            rem_d   = '0;
            quo_d   = dvd_mag;
            dvs_d   = dvs_mag;
            cnt_d   = '0;
            q_neg_d = signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_d = signed_div & dividend[WIDTH-1];
          end
        end
      end
      S_ZERO: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DONE;
          result_d = '0;
        end
      end
      S_BUSY: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CW'(1);
          // The final step registers the signed result so it is stable during DONE.
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = S_DONE;
            result_d = {(r_neg_q ? -step_rem : step_rem),
                        (q_neg_q ? -step_quo : step_quo)};
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  assign stall_request = ((state_q == S_IDLE) && start && !annul) ||
                         (state_q == S_ZERO) || (state_q == S_BUSY);
  assign result_valid  = (state_q == S_DONE);
  assign result        = result_q;

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Bench for ex_div_sequencer: directed corner cases plus random divides, checked
// against a 64-bit arithmetic reference through an expected-result queue.
module tb_ex_div_sequencer;

  localparam int W = 32;

  logic          clock;
  logic          reset;
  logic          start;
  logic          signed_div;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          annul;
  logic          stall_request;
  logic          result_valid;
  logic [2*W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  logic [2*W-1:0] last_result = '0;
  logic [2*W-1:0] exp_q[$];

  ex_div_sequencer #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .signed_div    (signed_div),
    .dividend      (dividend),
    .divisor       (divisor),
    .annul         (annul),
    .stall_request (stall_request),
    .result_valid  (result_valid),
    .result        (result)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned division in 64 bits, truncated to W bits.
  function automatic logic [2*W-1:0] model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y, q, r;
    if (b == '0) return '0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = {32'b0, a};
      y = {32'b0, b};
    end
    q = x / y;
    r = x % y;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // Monitor: every result_valid pulse must match the head of the expected queue.
  always @(negedge clock) begin
    if (!reset && result_valid) begin
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", result_valid, 1'b0);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        chk("result", result, e);
        last_result = e;
      end
    end
  end

  // Driver: called at a negedge; returns at a negedge with the DUT idle.
  task automatic run_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int annul_k, input int reset_k);
    int lat;
    bit bad_stall;
    bit done;
    logic [2*W-1:0] e;
    lat       = (b == '0) ? 2 : W + 1;
    bad_stall = 1'b0;
    done      = 1'b0;
    e         = model(sgn, a, b);
    signed_div = sgn;
    dividend   = a;
    divisor    = b;
    start      = 1'b1;
    if (annul_k < 0 && reset_k < 0) exp_q.push_back(e);
    #1 chk("stall_on_start", stall_request, 1'b1);
    for (int k = 1; k <= lat + 3 && !done; k++) begin
      @(negedge clock);
      if (k == annul_k) begin
        annul = 1'b1;
        start = 1'b0;
        @(negedge clock);
        annul = 1'b0;
        chk("annul_stall", stall_request, 1'b0);
        chk("annul_valid", result_valid, 1'b0);
        chk("annul_result", result, last_result);
        done = 1'b1;
      end else if (k == reset_k) begin
        reset = 1'b1;
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        last_result = '0;
        chk("midreset_result", result, '0);
        chk("midreset_valid", result_valid, 1'b0);
        chk("midreset_stall", stall_request, 1'b0);
        done = 1'b1;
      end else if (result_valid) begin
        chk("latency", k, lat);
        chk("stall_in_done", stall_request, 1'b0);
        start = 1'b0;
        done  = 1'b1;
        @(negedge clock);
        chk("result_hold", result, e);
      end else if (stall_request !== 1'b1) begin
        bad_stall = 1'b1;
      end
    end
    if (!done) chk("timeout", 1'b1, 1'b0);
    chk("stall_while_busy", bad_stall, 1'b0);
    if (annul_k >= 0 || reset_k >= 0) repeat (3) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; signed_div = 1'b0;
    dividend = '0; divisor = '0; annul = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_result", result, '0);
    chk("reset_valid", result_valid, 1'b0);
    chk("reset_stall", stall_request, 1'b0);
    @(negedge clock);

    run_div(1'b0, 32'd100, 32'd7, -1, -1);
    chk("divu_100_7", last_result, {32'd2, 32'd14});
    run_div(1'b1, -32'sd7, 32'd2, -1, -1);
    chk("div_m7_2", last_result, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_div(1'b1, 32'd7, -32'sd2, -1, -1);
    chk("div_7_m2", last_result, {32'd1, 32'hFFFFFFFD});
    run_div(1'b0, 32'd5, 32'd0, -1, -1);
    chk("divu_by_zero", last_result, 64'h0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, -1, -1);
    chk("div_overflow", last_result, {32'h0, 32'h80000000});
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, -1, -1);
    chk("divu_max_1", last_result, {32'h0, 32'hFFFFFFFF});

    run_div(1'b0, 32'd1000, 32'd3, 10, -1);
    run_div(1'b0, 32'd9, 32'd3, -1, -1);
    chk("after_annul_9_3", last_result, {32'd0, 32'd3});

    run_div(1'b1, 32'd12345, 32'd17, -1, 20);
    run_div(1'b0, 32'd100, 32'd7, -1, -1);
    run_div(1'b0, 32'd50, 32'd5, -1, -1);
    chk("b2b_gap", last_valid_cyc - prev_valid_cyc, 34);
    chk("b2b_second", last_result, {32'd0, 32'd10});

    for (int i = 0; i < 40; i++) begin
      bit sgn;
      logic [W-1:0] a, b;
      int ak;
      sgn = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = $urandom_range(1, 15);
        2:       b = -$urandom_range(1, 15);
        3:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      ak = -1;
      if ($urandom_range(0, 5) == 0) ak = (b == '0) ? 1 : $urandom_range(1, W);
      run_div(sgn, a, b, ak, -1);
    end

    repeat (4) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
